// File: rtl/ddr_app_responder.sv
// RAM-backed responder for a MIG-style DDR application interface.
// Write commands and write data pair in order. Reads return after a fixed latency. Refresh is optional.
module ddr_app_responder #(
  parameter int DEPTH_LOG2     = 10,
  parameter int ADDR_LSB       = 3,
  parameter int RD_LAT         = 4,
  parameter int WDF_DEPTH_LOG2 = 2,
  parameter int REF_PERIOD     = 0,
  parameter int REF_CYCLES     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [27:0]  app_addr,
  input  logic [2:0]   app_cmd,
  input  logic         app_en,
  output logic         app_rdy,
  input  logic [511:0] app_wdf_data,
  input  logic [63:0]  app_wdf_mask,
  input  logic         app_wdf_wren,
  input  logic         app_wdf_end,
  output logic         app_wdf_rdy,
  output logic [511:0] app_rd_data,
  output logic         app_rd_data_valid,
  output logic         app_rd_data_end
);

  localparam int DEPTH     = 1 << DEPTH_LOG2;
  localparam int WDF_DEPTH = 1 << WDF_DEPTH_LOG2;
  localparam int NSTG      = RD_LAT - 1;

  localparam logic [WDF_DEPTH_LOG2:0]   CNT_ZERO = {(WDF_DEPTH_LOG2+1){1'b0}};
  localparam logic [WDF_DEPTH_LOG2:0]   CNT_ONE  = {{WDF_DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [WDF_DEPTH_LOG2:0]   CNT_FULL = {1'b1, {WDF_DEPTH_LOG2{1'b0}}};
  localparam logic [WDF_DEPTH_LOG2-1:0] PTR_ZERO = {WDF_DEPTH_LOG2{1'b0}};
  localparam logic [WDF_DEPTH_LOG2-1:0] PTR_ONE  = {{(WDF_DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [31:0] REF_LAST = (REF_PERIOD > 0) ? 32'(REF_PERIOD - 1) : 32'd0;
  localparam logic [31:0] REF_CYC  = 32'(REF_CYCLES);
  localparam logic [2:0]  CMD_WR   = 3'b000;
  localparam logic [2:0]  CMD_RD   = 3'b001;

  typedef enum logic [0:0] {ST_ACCEPT = 1'b0, ST_WAIT_WDATA = 1'b1} state_t;

  state_t                  state_r, state_next_s;
  logic [DEPTH_LOG2-1:0]   cmd_idx_s, wait_idx_r, wait_idx_next_s, commit_idx_s;
  logic                    cmd_acc_s, wdf_push_s, wdf_pop_s, commit_s, rd_acc_s;
  logic [511:0]            fifo_data_r [WDF_DEPTH];
  logic [63:0]             fifo_mask_r [WDF_DEPTH];
  logic [WDF_DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
  logic [WDF_DEPTH_LOG2:0] count_r, count_next_s;
  logic                    fifo_empty_s;
  logic [511:0]            commit_data_s;
  logic [63:0]             commit_mask_s;
  logic [31:0]             ref_cnt_r, ref_cnt_next_s;
  logic                    refreshing_next_s;
  logic                    app_rdy_r, app_wdf_rdy_r;
  logic [NSTG-1:0]         rd_vld_r;
  logic [511:0]            rd_data_pipe_r [NSTG];
  logic                    rd_valid_r;
  logic [511:0]            rd_data_r;
  logic [511:0]            mem [DEPTH];
  logic                    unused_s;

  assign app_rdy           = app_rdy_r;
  assign app_wdf_rdy       = app_wdf_rdy_r;
  assign app_rd_data       = rd_data_r;
  assign app_rd_data_valid = rd_valid_r;
  assign app_rd_data_end   = rd_valid_r;
  assign unused_s          = ^{app_wdf_end, app_addr};

  assign cmd_acc_s    = app_en && app_rdy_r;
  assign wdf_push_s   = app_wdf_wren && app_wdf_rdy_r;
  assign fifo_empty_s = (count_r == CNT_ZERO);
  assign cmd_idx_s    = app_addr[ADDR_LSB +: DEPTH_LOG2];
  assign wdf_pop_s    = commit_s;
  // An empty FIFO with a beat arriving this cycle hands that beat straight to the RAM.
  assign commit_data_s = fifo_empty_s ? app_wdf_data : fifo_data_r[rd_ptr_r];
  assign commit_mask_s = fifo_empty_s ? app_wdf_mask : fifo_mask_r[rd_ptr_r];

  // FSM next state and the command decode.
  always_comb begin
    state_next_s    = state_r;
    wait_idx_next_s = wait_idx_r;
    commit_s        = 1'b0;
    commit_idx_s    = cmd_idx_s;
    rd_acc_s        = 1'b0;
    case (state_r)
      ST_ACCEPT: begin
        if (cmd_acc_s && (app_cmd == CMD_WR)) begin
          if (!fifo_empty_s || wdf_push_s) begin
            commit_s = 1'b1;
          end else begin
            state_next_s    = ST_WAIT_WDATA;
            wait_idx_next_s = cmd_idx_s;
          end
        end else if (cmd_acc_s && (app_cmd == CMD_RD)) begin
          rd_acc_s = 1'b1;
        end else begin
          rd_acc_s = 1'b0;
        end
      end
      ST_WAIT_WDATA: begin
        commit_idx_s = wait_idx_r;
        if (!fifo_empty_s || wdf_push_s) begin
          commit_s     = 1'b1;
          state_next_s = ST_ACCEPT;
        end else begin
          state_next_s = ST_WAIT_WDATA;
        end
      end
      default: begin
        state_next_s = ST_ACCEPT;
      end
    endcase
  end

  // FIFO occupancy and the refresh counter.
  always_comb begin
    count_next_s = count_r;
    case ({wdf_push_s, wdf_pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
    ref_cnt_next_s = 32'd0;
    if (REF_PERIOD > 0) begin
      if (ref_cnt_r == REF_LAST) begin
        ref_cnt_next_s = 32'd0;
      end else begin
        ref_cnt_next_s = ref_cnt_r + 32'd1;
      end
    end else begin
      ref_cnt_next_s = 32'd0;
    end
    refreshing_next_s = (REF_PERIOD > 0) && (ref_cnt_next_s < REF_CYC);
  end

  // Control state, handshake outputs and the read valid/data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_ACCEPT;
      wait_idx_r    <= {DEPTH_LOG2{1'b0}};
      wr_ptr_r      <= PTR_ZERO;
      rd_ptr_r      <= PTR_ZERO;
      count_r       <= CNT_ZERO;
      ref_cnt_r     <= 32'd0;
      app_rdy_r     <= 1'b0;
      app_wdf_rdy_r <= 1'b0;
      rd_vld_r      <= {NSTG{1'b0}};
      rd_valid_r    <= 1'b0;
      rd_data_r     <= 512'd0;
    end else begin
      state_r       <= state_next_s;
      wait_idx_r    <= wait_idx_next_s;
      count_r       <= count_next_s;
      ref_cnt_r     <= ref_cnt_next_s;
      app_rdy_r     <= (state_next_s == ST_ACCEPT) && !refreshing_next_s;
      app_wdf_rdy_r <= (count_next_s != CNT_FULL);
      if (wdf_push_s && !(wdf_pop_s && fifo_empty_s)) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (wdf_pop_s && !fifo_empty_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      rd_vld_r[0] <= rd_acc_s;
      for (int i = 1; i < NSTG; i++) begin
        rd_vld_r[i] <= rd_vld_r[i-1];
      end
      rd_valid_r <= rd_vld_r[NSTG-1];
      if (rd_vld_r[NSTG-1]) begin
        rd_data_r <= rd_data_pipe_r[NSTG-1];
      end
    end
  end

  // Storage: FIFO beats, masked RAM commits and the read-data delay line.
  always_ff @(posedge clk) begin
    if (!rst && wdf_push_s && !(wdf_pop_s && fifo_empty_s)) begin
      fifo_data_r[wr_ptr_r] <= app_wdf_data;
      fifo_mask_r[wr_ptr_r] <= app_wdf_mask;
    end
    if (!rst && commit_s) begin
      for (int b = 0; b < 64; b++) begin
        if (!commit_mask_s[b]) begin
          mem[commit_idx_s][b*8 +: 8] <= commit_data_s[b*8 +: 8];
        end
      end
    end
    // The old word is sampled here, so a commit on this same edge is not seen by the read.
    rd_data_pipe_r[0] <= mem[cmd_idx_s];
    for (int i = 1; i < NSTG; i++) begin
      rd_data_pipe_r[i] <= rd_data_pipe_r[i-1];
    end
  end

endmodule

// File: tb/tb_ddr_app_responder.sv
// Directed self-checking bench for ddr_app_responder: a default instance and a second instance with refresh enabled.
module tb_ddr_app_responder;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en, app_rdy;
  logic [511:0] app_wdf_data;
  logic [63:0]  app_wdf_mask;
  logic         app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [511:0] app_rd_data;
  logic         app_rd_data_valid, app_rd_data_end;

  logic [27:0]  r_addr;
  logic [2:0]   r_cmd;
  logic         r_en, r_rdy, r_wdf_rdy, r_valid, r_end;
  logic [511:0] r_rd_data;

  int n_cmp = 0;
  int n_err = 0;

  ddr_app_responder dut (
    .clk(clk), .rst(rst), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_rdy(app_rdy), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end)
  );

  ddr_app_responder #(.REF_PERIOD(32), .REF_CYCLES(4)) dut_ref (
    .clk(clk), .rst(rst), .app_addr(r_addr), .app_cmd(r_cmd), .app_en(r_en),
    .app_rdy(r_rdy), .app_wdf_data(512'd0), .app_wdf_mask(64'd0),
    .app_wdf_wren(1'b0), .app_wdf_end(1'b0), .app_wdf_rdy(r_wdf_rdy),
    .app_rd_data(r_rd_data), .app_rd_data_valid(r_valid), .app_rd_data_end(r_end)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    app_en = 1'b0; app_cmd = 3'b000; app_addr = 28'h0;
    app_wdf_wren = 1'b0; app_wdf_end = 1'b0; app_wdf_data = 512'd0; app_wdf_mask = 64'd0;
  endtask

  function automatic logic [511:0] fill(input logic [7:0] b);
    return {64{b}};
  endfunction

  task automatic put_write(input logic [27:0] addr, input logic [511:0] d, input logic [63:0] m);
    app_en = 1'b1; app_cmd = 3'b000; app_addr = addr;
    app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = d; app_wdf_mask = m;
  endtask

  task automatic issue_read(input logic [27:0] addr, output bit ok);
    ok = 1'b0;
    app_en = 1'b1; app_cmd = 3'b001; app_addr = addr;
    for (int i = 0; i < 50; i++) begin
      if (app_rdy === 1'b1) begin ok = 1'b1; break; end
      step();
    end
    step();
    app_en = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output logic [511:0] d, output logic vend);
    lat = -1; d = 512'd0; vend = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (app_rd_data_valid === 1'b1) begin
        lat = i; d = app_rd_data; vend = app_rd_data_end;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); r_en = 1'b0; r_cmd = 3'b001; r_addr = 28'h0;
    step(); step();
    n_cmp++; if (app_rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy: got %b expected 0", app_rdy); end
    n_cmp++; if (app_wdf_rdy !== 1'b0) begin n_err++; $display("FAIL reset_wdf_rdy: got %b expected 0", app_wdf_rdy); end
    n_cmp++; if (app_rd_data_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", app_rd_data_valid); end
    n_cmp++; if (app_rd_data_end !== 1'b0) begin n_err++; $display("FAIL reset_end: got %b expected 0", app_rd_data_end); end
    n_cmp++; if (app_rd_data !== 512'd0) begin n_err++; $display("FAIL reset_data: got %h expected 0", app_rd_data); end
    rst = 1'b0;
    step();
    n_cmp++; if (app_rdy !== 1'b1) begin n_err++; $display("FAIL post_reset_rdy: got %b expected 1", app_rdy); end
    n_cmp++; if (app_wdf_rdy !== 1'b1) begin n_err++; $display("FAIL post_reset_wdf_rdy: got %b expected 1", app_wdf_rdy); end
  endtask

  task automatic test_write_read();
    int lat; logic [511:0] d; logic vend; bit ok;
    put_write(28'h10, fill(8'hA5), 64'd0);
    step();
    idle();
    issue_read(28'h10, ok);
    wait_valid(lat, d, vend);
    n_cmp++; if (!ok || lat != 4) begin n_err++; $display("FAIL wr_rd_latency: got %0d (accepted %0d) expected 4", lat, ok); end
    n_cmp++; if (d !== fill(8'hA5)) begin n_err++; $display("FAIL wr_rd_data: got %h expected a5..", d); end
    n_cmp++; if (vend !== 1'b1) begin n_err++; $display("FAIL wr_rd_end: got %b expected 1", vend); end
    step();
    n_cmp++; if (app_rd_data_valid !== 1'b0) begin n_err++; $display("FAIL wr_rd_one_pulse: got %b expected 0", app_rd_data_valid); end
    n_cmp++; if (app_rd_data !== fill(8'hA5)) begin n_err++; $display("FAIL wr_rd_hold: got %h expected a5..", app_rd_data); end
  endtask

  task automatic test_reset_inflight();
    int lat; logic [511:0] d; logic vend; bit ok; int seen;
    for (int i = 0; i < 3; i++) begin
      app_en = 1'b1; app_cmd = 3'b001; app_addr = 28'h10;
      n_cmp++; if (app_rdy !== 1'b1) begin n_err++; $display("FAIL inflight_rdy_%0d: got %b expected 1", i, app_rdy); end
      step();
    end
    idle();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (app_rdy !== 1'b0) begin n_err++; $display("FAIL inflight_rst_rdy: got %b expected 0", app_rdy); end
    seen = (app_rd_data_valid === 1'b1) ? 1 : 0;
    step();
    n_cmp++; if (app_rdy !== 1'b1) begin n_err++; $display("FAIL inflight_first_rdy: got %b expected 1", app_rdy); end
    for (int i = 0; i < 8; i++) begin
      if (app_rd_data_valid !== 1'b0) seen++;
      step();
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL inflight_discard: got %0d valid cycles expected 0", seen); end
    issue_read(28'h10, ok);
    wait_valid(lat, d, vend);
    n_cmp++; if (!ok || lat != 4 || d !== fill(8'hA5)) begin n_err++; $display("FAIL inflight_ram_kept: got lat %0d data %h expected lat 4 data a5..", lat, d); end
  endtask

  task automatic test_alias_and_other_cmd();
    int lat; logic [511:0] d; logic vend; bit ok; int seen;
    put_write(28'h2017, fill(8'h3C), 64'd0);
    step();
    idle();
    app_en = 1'b1; app_cmd = 3'b111; app_addr = 28'h10;
    n_cmp++; if (app_rdy !== 1'b1) begin n_err++; $display("FAIL other_cmd_rdy: got %b expected 1", app_rdy); end
    step();
    idle();
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (app_rd_data_valid !== 1'b0 || app_rdy !== 1'b1) seen++;
      step();
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL other_cmd_no_effect: got %0d bad cycles expected 0", seen); end
    issue_read(28'hABC2010, ok);
    wait_valid(lat, d, vend);
    n_cmp++; if (!ok || lat != 4 || d !== fill(8'h3C)) begin n_err++; $display("FAIL alias_read: got lat %0d data %h expected lat 4 data 3c..", lat, d); end
  endtask

  task automatic test_wait_wdata();
    int lat; logic [511:0] d; logic vend; bit ok; logic [511:0] pat;
    for (int i = 0; i < 64; i++) pat[(63-i)*8 +: 8] = 8'(i + 1);
    app_en = 1'b1; app_cmd = 3'b000; app_addr = 28'h20;
    n_cmp++; if (app_rdy !== 1'b1) begin n_err++; $display("FAIL wait_cmd_rdy: got %b expected 1", app_rdy); end
    step();
    idle();
    n_cmp++; if (app_rdy !== 1'b0) begin n_err++; $display("FAIL wait_rdy_low1: got %b expected 0", app_rdy); end
    step();
    n_cmp++; if (app_rdy !== 1'b0) begin n_err++; $display("FAIL wait_rdy_low2: got %b expected 0", app_rdy); end
    step();
    app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = pat; app_wdf_mask = 64'd0;
    n_cmp++; if (app_rdy !== 1'b0 || app_wdf_rdy !== 1'b1) begin n_err++; $display("FAIL wait_push_cycle: got rdy %b wdf_rdy %b expected 0 1", app_rdy, app_wdf_rdy); end
    step();
    idle();
    n_cmp++; if (app_rdy !== 1'b1) begin n_err++; $display("FAIL wait_rdy_back: got %b expected 1", app_rdy); end
    issue_read(28'h20, ok);
    wait_valid(lat, d, vend);
    n_cmp++; if (!ok || lat != 4 || d !== pat) begin n_err++; $display("FAIL wait_read: got lat %0d data %h expected lat 4 data %h", lat, d, pat); end
  endtask

  task automatic test_fifo_fill();
    for (int n = 0; n < 4; n++) begin
      app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = fill(8'(8'h11 + n)); app_wdf_mask = 64'd0;
      n_cmp++; if (app_wdf_rdy !== 1'b1) begin n_err++; $display("FAIL fifo_push_rdy_%0d: got %b expected 1", n, app_wdf_rdy); end
      step();
    end
    idle();
    n_cmp++; if (app_wdf_rdy !== 1'b0) begin n_err++; $display("FAIL fifo_full: got %b expected 0", app_wdf_rdy); end
    for (int n = 0; n < 4; n++) begin
      app_en = 1'b1; app_cmd = 3'b000; app_addr = 28'(n * 8);
      n_cmp++; if (app_rdy !== 1'b1) begin n_err++; $display("FAIL fifo_cmd_rdy_%0d: got %b expected 1", n, app_rdy); end
      step();
    end
    idle();
    n_cmp++; if (app_wdf_rdy !== 1'b1) begin n_err++; $display("FAIL fifo_drained: got %b expected 1", app_wdf_rdy); end
    for (int n = 0; n < 4; n++) begin
      app_en = 1'b1; app_cmd = 3'b001; app_addr = 28'(n * 8);
      n_cmp++; if (app_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_rd_rdy_%0d: got %b expected 1", n, app_rdy); end
      step();
    end
    idle();
    for (int n = 0; n < 4; n++) begin
      n_cmp++;
      if (app_rd_data_valid !== 1'b1 || app_rd_data !== fill(8'(8'h11 + n))) begin
        n_err++; $display("FAIL b2b_rd_data_%0d: got valid %b data %h expected valid 1 data %h", n, app_rd_data_valid, app_rd_data, fill(8'(8'h11 + n)));
      end
      step();
    end
    n_cmp++; if (app_rd_data_valid !== 1'b0) begin n_err++; $display("FAIL b2b_rd_tail: got %b expected 0", app_rd_data_valid); end
  endtask

  task automatic test_mask();
    int lat; logic [511:0] d; logic vend; bit ok; logic [511:0] exp_d;
    exp_d = {{48{8'h00}}, {16{8'hFF}}};
    put_write(28'h30, fill(8'hFF), 64'd0);
    step();
    put_write(28'h30, fill(8'h00), 64'h00000000_0000FFFF);
    step();
    idle();
    issue_read(28'h30, ok);
    wait_valid(lat, d, vend);
    n_cmp++; if (!ok || lat != 4 || d !== exp_d) begin n_err++; $display("FAIL mask_read: got lat %0d data %h expected lat 4 data %h", lat, d, exp_d); end
  endtask

  task automatic test_refresh();
    logic [79:0] exp_v;
    int low_cnt, acc_cnt, run, bad_v, bad_run;
    bit seen_high;
    exp_v = 80'd0; low_cnt = 0; acc_cnt = 0; run = 0; bad_v = 0; bad_run = 0; seen_high = 1'b0;
    r_en = 1'b1; r_cmd = 3'b001; r_addr = 28'h0;
    for (int t = 0; t < 72; t++) begin
      if (t == 64) r_en = 1'b0;
      if (r_valid !== exp_v[t]) begin
        bad_v++;
        $display("FAIL refresh_valid_t%0d: got %b expected %b", t, r_valid, exp_v[t]);
      end
      if (t < 64) begin
        if (r_rdy === 1'b1) begin
          exp_v[t+4] = 1'b1;
          acc_cnt++;
          if (seen_high && run != 0) begin
            n_cmp++;
            if (run != 4) begin n_err++; bad_run++; $display("FAIL refresh_run: got %0d low cycles expected 4", run); end
          end
          seen_high = 1'b1;
          run = 0;
        end else begin
          low_cnt++;
          run++;
        end
      end
      step();
    end
    n_cmp++; if (bad_v != 0) begin n_err++; $display("FAIL refresh_valid_total: got %0d bad cycles expected 0", bad_v); end
    n_cmp++; if (low_cnt != 8) begin n_err++; $display("FAIL refresh_low_count: got %0d expected 8", low_cnt); end
    n_cmp++; if (acc_cnt != 56) begin n_err++; $display("FAIL refresh_accepted: got %0d expected 56", acc_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_read();
    test_reset_inflight();
    test_alias_and_other_cmd();
    test_wait_wdata();
    test_fifo_fill();
    test_mask();
    test_refresh();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
